// File: rtl/wb_mem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// wb_mem_arbiter
//   Two-master, one-slave Wishbone arbiter sharing the on-chip byte memory between the core's
//   instruction-fetch master (I) and load/store master (D). A grant covers one whole transfer;
//   under contention the masters alternate round-robin. Responses are routed only to the master
//   that owns the current grant. A dead IDLE cycle always separates two grants.
//
//   Optional feature (macro WB_ARB_TIMEOUT_EN): a busy-cycle counter forces an error response
//   and drops the slave cycle if the slave has not answered after TIMEOUT_CYCLES busy cycles.
//   With the macro undefined there is no counter and a grant waits indefinitely.
//
// Parameters
//   AW             address width
//   DW             data width (byte-select width is DW/8)
//   TIMEOUT_CYCLES busy cycles before a forced error (timeout build only, must be >= 1)
//
// Ports
//   clk, rst                    clock; synchronous active-high reset
//   i_* inputs                  I-master addr/dat/sel/cyc/stb/we
//   d_* inputs                  D-master addr/dat/sel/cyc/stb/we
//   i_dat_o/i_ack_o/i_err_o     response to I master
//   d_dat_o/d_ack_o/d_err_o     response to D master
//   m_addr_o .. m_we_o          request to the memory slave
//   m_dat_i/m_ack_i/m_err_i     response from the memory slave
// ---------------------------------------------------------------------------------------------
module wb_mem_arbiter #(
    parameter int unsigned AW             = 32,
    parameter int unsigned DW             = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clk,
    input  logic            rst,

    // I master
    input  logic [AW-1:0]   i_addr_i,
    input  logic [DW-1:0]   i_dat_i,
    input  logic [DW/8-1:0] i_sel_i,
    input  logic            i_cyc_i,
    input  logic            i_stb_i,
    input  logic            i_we_i,
    output logic [DW-1:0]   i_dat_o,
    output logic            i_ack_o,
    output logic            i_err_o,

    // D master
    input  logic [AW-1:0]   d_addr_i,
    input  logic [DW-1:0]   d_dat_i,
    input  logic [DW/8-1:0] d_sel_i,
    input  logic            d_cyc_i,
    input  logic            d_stb_i,
    input  logic            d_we_i,
    output logic [DW-1:0]   d_dat_o,
    output logic            d_ack_o,
    output logic            d_err_o,

    // Memory slave
    output logic [AW-1:0]   m_addr_o,
    output logic [DW-1:0]   m_dat_o,
    output logic [DW/8-1:0] m_sel_o,
    output logic            m_cyc_o,
    output logic            m_stb_o,
    output logic            m_we_o,
    input  logic [DW-1:0]   m_dat_i,
    input  logic            m_ack_i,
    input  logic            m_err_i
);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBusyI = 2'd1,
        StBusyD = 2'd2
    } state_e;

    state_e state_q, state_d;
    // 1: the most recent grant went to D, so I wins the next tie.
    logic   last_was_d_q, last_was_d_d;

    logic i_req, d_req;
    logic slave_done;
    logic timeout;

    assign i_req      = i_cyc_i & i_stb_i;
    assign d_req      = d_cyc_i & d_stb_i;
    assign slave_done = m_ack_i | m_err_i;

`ifdef WB_ARB_TIMEOUT_EN
    localparam int unsigned CntW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);

    // Holds the number of busy cycles already completed in the current grant.
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (state_q == StIdle) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Fires on the TIMEOUT_CYCLES-th busy cycle, unless the slave answers in that same cycle.
    assign timeout = (state_q != StIdle) && (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) && !slave_done;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        last_was_d_d = last_was_d_q;

        m_addr_o = '0;
        m_dat_o  = '0;
        m_sel_o  = '0;
        m_cyc_o  = 1'b0;
        m_stb_o  = 1'b0;
        m_we_o   = 1'b0;
        i_dat_o  = '0;
        i_ack_o  = 1'b0;
        i_err_o  = 1'b0;
        d_dat_o  = '0;
        d_ack_o  = 1'b0;
        d_err_o  = 1'b0;

        // Outputs are gated during reset so a transfer in flight is abandoned silently.
        if (!rst) begin
            unique case (state_q)
                StIdle: begin
                    if (i_req && (!d_req || last_was_d_q)) begin
                        state_d = StBusyI;
                    end else if (d_req) begin
                        state_d = StBusyD;
                    end
                end

                StBusyI: begin
                    m_addr_o = i_addr_i;
                    m_dat_o  = i_dat_i;
                    m_sel_o  = i_sel_i;
                    m_we_o   = i_we_i;
                    m_cyc_o  = i_cyc_i & ~timeout;
                    m_stb_o  = i_stb_i & ~timeout;
                    i_dat_o  = m_dat_i;
                    i_ack_o  = m_ack_i;
                    i_err_o  = m_err_i | timeout;
                    // An ack in the same cycle as an abort still completes normally.
                    if (slave_done || !i_cyc_i || timeout) begin
                        state_d      = StIdle;
                        last_was_d_d = 1'b0;
                    end
                end

                StBusyD: begin
                    m_addr_o = d_addr_i;
                    m_dat_o  = d_dat_i;
                    m_sel_o  = d_sel_i;
                    m_we_o   = d_we_i;
                    m_cyc_o  = d_cyc_i & ~timeout;
                    m_stb_o  = d_stb_i & ~timeout;
                    d_dat_o  = m_dat_i;
                    d_ack_o  = m_ack_i;
                    d_err_o  = m_err_i | timeout;
                    if (slave_done || !d_cyc_i || timeout) begin
                        state_d      = StIdle;
                        last_was_d_d = 1'b1;
                    end
                end

                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_was_d_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            last_was_d_q <= last_was_d_d;
        end
    end

endmodule
